// File: rtl/dport_scrambler_n.sv
// DisplayPort-style symbol scrambler: 16-bit LFSR keystream XORed onto data symbols,
// with every SR_INTERVAL-th BS control symbol replaced by SR and the LFSR re-seeded.
module dport_scrambler_n #(
  parameter int SYMS        = 2,
  parameter int SR_INTERVAL = 512
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                scr_en,
  input  logic                inval,
  input  logic [8*SYMS-1:0]   indata,
  input  logic [SYMS-1:0]     inisk,
  output logic                outval,
  output logic [8*SYMS-1:0]   outdata,
  output logic [SYMS-1:0]     outisk,
  output logic [SYMS-1:0]     outsr
);

  localparam int          DATA_W    = 8 * SYMS;
  localparam int          CNT_W     = $clog2(SR_INTERVAL);
  localparam logic [7:0]  SYM_BS    = 8'hBC;
  localparam logic [7:0]  SYM_SR    = 8'h1C;
  localparam logic [15:0] LFSR_SEED = 16'hFFFF;

  logic [15:0]       lfsr_q, lfsr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              val_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SYMS-1:0]   isk_q, isk_d;
  logic [SYMS-1:0]   sr_q, sr_d;

  logic [15:0]       s_w;
  logic [CNT_W-1:0]  c_w;
  logic [23:0]       step_w;
  logic [7:0]        sym_w;
  logic              is_bs_w;

  // Eight serial LFSR steps; returns {next_state, key_byte} with key[0] emitted first.
  function automatic logic [23:0] lfsr_byte(input logic [15:0] seed);
    logic [15:0] s;
    logic [7:0]  key;
    s   = seed;
    key = '0;
    for (int b = 0; b < 8; b++) begin
      key[b] = s[15];
      s      = {s[14:0], 1'b0} ^ ({16{key[b]}} & 16'h0039);
    end
    return {s, key};
  endfunction

  always_comb begin
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    isk_d   = isk_q;
    sr_d    = sr_q;
    s_w     = lfsr_q;
    c_w     = cnt_q;
    step_w  = '0;
    sym_w   = '0;
    is_bs_w = 1'b0;
    if (inval) begin
      if (!scr_en) begin
        data_d = indata;
        isk_d  = inisk;
        sr_d   = '0;
        lfsr_d = LFSR_SEED;
        cnt_d  = '0;
      end else begin
        isk_d = inisk;
        sr_d  = '0;
        // Symbols chain through s_w/c_w so a later symbol sees earlier updates.
        for (int i = 0; i < SYMS; i++) begin
          sym_w   = indata[8*i +: 8];
          is_bs_w = inisk[i] && (sym_w == SYM_BS);
          if (is_bs_w && (c_w == '0)) begin
            data_d[8*i +: 8] = SYM_SR;
            sr_d[i]          = 1'b1;
            s_w              = LFSR_SEED;
          end else begin
            step_w           = lfsr_byte(s_w);
            s_w              = step_w[23:8];
            data_d[8*i +: 8] = inisk[i] ? sym_w : (sym_w ^ step_w[7:0]);
          end
          if (is_bs_w) c_w = c_w + CNT_W'(1);
        end
        lfsr_d = s_w;
        cnt_d  = c_w;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
      cnt_q  <= '0;
      val_q  <= 1'b0;
      data_q <= '0;
      isk_q  <= '0;
      sr_q   <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_d;
      val_q  <= inval;
      data_q <= data_d;
      isk_q  <= isk_d;
      sr_q   <= sr_d;
    end
  end

  assign outval  = val_q;
  assign outdata = data_q;
  assign outisk  = isk_q;
  assign outsr   = sr_q;

endmodule

// File: tb/tb_dport_scrambler_n.sv
// Bench for dport_scrambler_n: a 2-symbol instance (SR_INTERVAL 512) and a 4-symbol
// instance (SR_INTERVAL 8) checked every cycle against a keystream/counter reference model.
module tb_dport_scrambler_n;

  localparam int A_SYMS = 2;
  localparam int A_INT  = 512;
  localparam int B_SYMS = 4;
  localparam int B_INT  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_en, a_val;
  logic [15:0] a_d;
  logic [1:0]  a_k;
  logic        a_outval;
  logic [15:0] a_outdata;
  logic [1:0]  a_outisk, a_outsr;

  logic        b_rst, b_en, b_val;
  logic [31:0] b_d;
  logic [3:0]  b_k;
  logic        b_outval;
  logic [31:0] b_outdata;
  logic [3:0]  b_outisk, b_outsr;

  dport_scrambler_n #(.SYMS(A_SYMS), .SR_INTERVAL(A_INT)) dut_a (
    .clk(clk), .reset(a_rst), .scr_en(a_en), .inval(a_val), .indata(a_d), .inisk(a_k),
    .outval(a_outval), .outdata(a_outdata), .outisk(a_outisk), .outsr(a_outsr)
  );

  dport_scrambler_n #(.SYMS(B_SYMS), .SR_INTERVAL(B_INT)) dut_b (
    .clk(clk), .reset(b_rst), .scr_en(b_en), .inval(b_val), .indata(b_d), .inisk(b_k),
    .outval(b_outval), .outdata(b_outdata), .outisk(b_outisk), .outsr(b_outsr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state, index 0 = instance A, 1 = instance B.
  int          m_s[2];
  int          m_c[2];
  logic        m_ov[2];
  logic [31:0] m_od[2];
  logic [3:0]  m_ok[2];
  logic [3:0]  m_sr[2];

  task automatic key_byte(input int s_in, output int s_out, output logic [7:0] key);
    int s;
    int fb;
    s = s_in;
    for (int i = 0; i < 8; i++) begin
      fb     = (s >> 15) & 1;
      key[i] = (fb != 0);
      s      = ((s << 1) & 'hFFFF) ^ (fb != 0 ? 'h0039 : 0);
    end
    s_out = s;
  endtask

  task automatic model(input int id, input int syms, input int interval, input logic rst,
                       input logic en, input logic val, input logic [31:0] d, input logic [3:0] k);
    logic [7:0] sym, key;
    int         s_nxt;
    bit         is_bs;
    if (rst) begin
      m_s[id] = 'hFFFF; m_c[id] = 0; m_ov[id] = 1'b0;
      m_od[id] = '0; m_ok[id] = '0; m_sr[id] = '0;
      return;
    end
    m_ov[id] = val;
    if (!val) return;
    if (!en) begin
      m_od[id] = d; m_ok[id] = k; m_sr[id] = '0;
      m_s[id] = 'hFFFF; m_c[id] = 0;
      return;
    end
    m_ok[id] = k;
    m_sr[id] = '0;
    m_od[id] = '0;
    for (int i = 0; i < syms; i++) begin
      sym   = d[8*i +: 8];
      is_bs = k[i] && (sym == 8'hBC);
      if (is_bs && m_c[id] == 0) begin
        m_od[id][8*i +: 8] = 8'h1C;
        m_sr[id][i]        = 1'b1;
        m_s[id]            = 'hFFFF;
      end else begin
        key_byte(m_s[id], s_nxt, key);
        m_s[id] = s_nxt;
        m_od[id][8*i +: 8] = k[i] ? sym : (sym ^ key);
      end
      if (is_bs) m_c[id] = (m_c[id] + 1) % interval;
    end
  endtask

  task automatic tick();
    model(0, A_SYMS, A_INT, a_rst, a_en, a_val, {16'h0, a_d}, {2'b00, a_k});
    model(1, B_SYMS, B_INT, b_rst, b_en, b_val, b_d, b_k);
    @(posedge clk);
    #1;
    chk("a_val",  a_outval,  m_ov[0]);
    chk("a_data", a_outdata, m_od[0][15:0]);
    chk("a_isk",  a_outisk,  m_ok[0][1:0]);
    chk("a_sr",   a_outsr,   m_sr[0][1:0]);
    chk("b_val",  b_outval,  m_ov[1]);
    chk("b_data", b_outdata, m_od[1]);
    chk("b_isk",  b_outisk,  m_ok[1]);
    chk("b_sr",   b_outsr,   m_sr[1]);
  endtask

  task automatic a_beat(input logic en, input logic val, input logic [15:0] d, input logic [1:0] k);
    a_rst = 1'b0; a_en = en; a_val = val; a_d = d; a_k = k;
    tick();
  endtask

  function automatic logic [7:0] rand_sym(output logic isk);
    int r;
    r = $urandom_range(0, 3);
    isk = (r <= 1);
    if (r == 0) return 8'hBC;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    int   sr_seen;
    logic ik;

    a_rst = 1'b1; a_en = 1'b0; a_val = 1'b0; a_d = '0; a_k = '0;
    b_rst = 1'b1; b_en = 1'b0; b_val = 1'b0; b_d = '0; b_k = '0;
    tick();
    a_rst = 1'b1; a_en = 1'b1; a_val = 1'b1; a_d = 16'hFFFF; a_k = 2'b11;
    tick();
    chk("rst_val",  a_outval,  1'b0);
    chk("rst_data", a_outdata, 16'h0);
    chk("rst_sr",   a_outsr,   2'b00);
    b_rst = 1'b0;

    // First beat after reset: BS replaced by SR, then reference key stream.
    a_beat(1'b1, 1'b1, 16'h00BC, 2'b01);
    chk("sr_first_data", a_outdata, 16'hFF1C);
    chk("sr_first_flag", a_outsr,   2'b01);
    chk("sr_first_isk",  a_outisk,  2'b01);
    a_beat(1'b1, 1'b1, 16'h0000, 2'b00);
    chk("key_C017", a_outdata, 16'hC017);
    a_beat(1'b1, 1'b1, 16'h0000, 2'b00);
    chk("key_B214", a_outdata, 16'hB214);
    a_beat(1'b1, 1'b1, 16'h0000, 2'b00);
    chk("key_02E7", a_outdata, 16'h02E7);
    chk("key_isk",  a_outisk,  2'b00);

    // Bypass, then scrambling resumes from the seed.
    a_beat(1'b0, 1'b1, 16'h5AA5, 2'b00);
    chk("byp_data", a_outdata, 16'h5AA5);
    chk("byp_sr",   a_outsr,   2'b00);
    a_beat(1'b1, 1'b1, 16'h0000, 2'b00);
    chk("post_byp_key", a_outdata, 16'h17FF);
    // Idle cycle does not advance the keystream.
    a_beat(1'b1, 1'b0, 16'h0000, 2'b00);
    chk("idle_val",  a_outval,  1'b0);
    chk("idle_hold", a_outdata, 16'h17FF);
    a_beat(1'b1, 1'b1, 16'h0000, 2'b00);
    chk("idle_contig", a_outdata, 16'hB214 ^ 16'hB214 ^ 16'h14C0);
    a_rst = 1'b1; a_val = 1'b1; tick();
    a_beat(1'b1, 1'b1, 16'h0000, 2'b00);
    chk("rst_restart", a_outdata, 16'h17FF);

    // 513 beats, one BS each: only BS #0 and #512 become SR.
    a_beat(1'b0, 1'b1, 16'h0000, 2'b00);
    sr_seen = 0;
    for (int n = 0; n < 513; n++) begin
      a_beat(1'b1, 1'b1, {8'($urandom_range(0, 255)), 8'hBC}, 2'b01);
      sr_seen += int'(a_outsr[0]);
      if (n == 1)   chk("bs1_pass", a_outdata[7:0], 8'hBC);
      if (n == 511) chk("bs511_pass", a_outsr, 2'b00);
      if (n == 512) chk("bs512_sr", a_outdata[7:0], 8'h1C);
    end
    chk("sr_count", sr_seen, 2);

    // Four-symbol instance: BS at C=7 passes, second BS in the same beat hits C=0.
    a_val = 1'b0;
    b_en = 1'b1; b_val = 1'b1; b_rst = 1'b0;
    b_d = 32'h000000BC; b_k = 4'b0001;
    tick();
    chk("b_first_sr", b_outsr, 4'b0001);
    for (int n = 0; n < 6; n++) tick();
    b_d = {8'h00, 8'hBC, 8'h33, 8'hBC}; b_k = 4'b0101;
    tick();
    chk("b_bs_pass", b_outdata[7:0],   8'hBC);
    chk("b_bs_sr",   b_outdata[23:16], 8'h1C);
    chk("b_key_ff",  b_outdata[31:24], 8'hFF);
    chk("b_sr_flag", b_outsr,          4'b0100);

    // Randomized traffic on both instances.
    for (int n = 0; n < 3000; n++) begin
      a_rst = ($urandom_range(0, 59) == 0);
      a_en  = ($urandom_range(0, 7) != 0);
      a_val = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < A_SYMS; i++) begin
        a_d[8*i +: 8] = rand_sym(ik);
        a_k[i] = ik;
      end
      b_rst = ($urandom_range(0, 59) == 0);
      b_en  = ($urandom_range(0, 7) != 0);
      b_val = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < B_SYMS; i++) begin
        b_d[8*i +: 8] = rand_sym(ik);
        b_k[i] = ik;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
